// File: rtl/sccb_target.sv
// SCCB responder: decodes 3-phase writes and 2-phase pointer writes into register strobes.
// Optional read path enabled by defining SCCB_TARGET_READ_EN.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ID        | shifting device ID byte
// ADDR_H    | shifting register address high byte
// ADDR_L    | shifting register address low byte
// DATA      | shifting write data byte
// RD_DATA   | driving read data byte to the master
// WAIT_STOP | transaction done or not ours, ignore bits until STOP
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h78,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        SIOC,
  input  logic        SIOD_i,
  output logic        SIOD_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ID        = 3'd1;
  localparam logic [2:0] ADDR_H    = 3'd2;
  localparam logic [2:0] ADDR_L    = 3'd3;
  localparam logic [2:0] DATA      = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] WAIT_STOP = 3'd6;

`ifdef SCCB_TARGET_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sioc_sync, siod_sync;
  logic       sioc_s, siod_s, sioc_d, siod_d;
  logic       sioc_rise, sioc_fall, bus_start, bus_stop;
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift, addr_h, data_q;
  logic [7:0] byte_in;
  logic       ack_q, ack_next, id_match;
  logic       wr_done, wr_go;
  logic       wr_open, stop_ok;

  assign sioc_s = sioc_sync[SYNC_STAGES-1];
  assign siod_s = siod_sync[SYNC_STAGES-1];

  // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_d    <= 1'b1;
      siod_d    <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], SIOC};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], SIOD_i};
      sioc_d    <= sioc_s;
      siod_d    <= siod_s;
    end
  end

  // SIOC must be stably high for START/STOP, so coincident edges read as data.
  assign sioc_rise = sioc_s & ~sioc_d;
  assign sioc_fall = ~sioc_s & sioc_d;
  assign bus_start = sioc_s & sioc_d & siod_d & ~siod_s;
  assign bus_stop  = sioc_s & sioc_d & ~siod_d & siod_s;

  assign byte_in  = {shift[6:0], siod_s};
  assign id_match = (byte_in[7:1] == DEV_ID[7:1]);

  always_comb begin
    ack_next = 1'b0;
    case (state)
      ID:                   ack_next = id_match & (READ_EN | ~byte_in[0]);
      ADDR_H, ADDR_L, DATA: ack_next = 1'b1;
      default:              ack_next = 1'b0;
    endcase
  end

  // The SIOC rise that precedes STOP/Sr samples one dummy bit, so DATA with
  // at most one bit counted still means the pointer write finished cleanly.
  assign stop_ok = (state == WAIT_STOP) || ((state == DATA) && (bit_cnt <= 4'd1));
  assign wr_open = (state == ADDR_H) || (state == ADDR_L) ||
                   ((state == DATA) && (bit_cnt > 4'd1)) ||
                   ((state == WAIT_STOP) && wr_done);

`ifdef SCCB_TARGET_READ_EN
  logic [7:0] rd_shift;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      addr_h   <= 8'd0;
      data_q   <= 8'd0;
      ack_q    <= 1'b0;
      wr_done  <= 1'b0;
      wr_go    <= 1'b0;
      SIOD_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 16'd0;
      wr_data  <= 8'd0;
      rd_addr  <= 16'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      rd_shift <= 8'd0;
`endif
    end else begin
      err      <= 1'b0;
      wr_valid <= 1'b0;
      if (wr_go) begin
        wr_valid <= 1'b1;
        wr_addr  <= rd_addr;
        wr_data  <= data_q;
        wr_go    <= 1'b0;
      end
      if (bus_start) begin
        err     <= wr_open;
        state   <= ID;
        bit_cnt <= 4'd0;
        ack_q   <= 1'b0;
        wr_done <= 1'b0;
        SIOD_oe <= 1'b0;
        busy    <= 1'b1;
      end else if (bus_stop) begin
        if (state != IDLE) begin
          err   <= ~stop_ok;
          wr_go <= (state == WAIT_STOP) && wr_done;
        end
        state   <= IDLE;
        bit_cnt <= 4'd0;
        wr_done <= 1'b0;
        SIOD_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (sioc_rise && (state != IDLE) && (state != WAIT_STOP)) begin
        if (bit_cnt == 4'd8) begin
          bit_cnt <= 4'd0;
          case (state)
            ID:      state <= ack_q ? (shift[0] ? RD_DATA : ADDR_H) : WAIT_STOP;
            ADDR_H:  begin addr_h <= shift; state <= ADDR_L; end
            ADDR_L:  begin rd_addr <= {addr_h, shift}; state <= DATA; end
            DATA:    begin data_q <= shift; wr_done <= 1'b1; state <= WAIT_STOP; end
            default: state <= WAIT_STOP;
          endcase
        end else begin
          shift   <= byte_in;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            ack_q <= ack_next;
`ifdef SCCB_TARGET_READ_EN
            if (state == ID) rd_shift <= rd_data;
`endif
          end
        end
      end else if (sioc_fall) begin
        if (bit_cnt == 4'd8) SIOD_oe <= ack_q;
`ifdef SCCB_TARGET_READ_EN
        else if (state == RD_DATA) SIOD_oe <= ~rd_shift[3'd7 - bit_cnt[2:0]];
`endif
        else SIOD_oe <= 1'b0;
      end
    end
  end

endmodule
